// File: rtl/instr_fetch_unit.sv
// Fetch stage: samples PC, runs a req/ack memory read, hands the word to decode.
// Optional FETCH_TIMEOUT_EN adds a sticky timeout error on stuck memory reads.
module instr_fetch_unit #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              flush,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              pc_advance,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              fetch_err
);

   typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, ERR} state_t;

   state_t            state_q, state_d;
   logic              mem_req_d, instr_valid_d;
   logic [ADDR_W-1:0] mem_addr_d, instr_pc_d;
   logic [DATA_W-1:0] instr_d;
   logic              tmo;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
      end else begin
         state_q     <= state_d;
         mem_req     <= mem_req_d;
         mem_addr    <= mem_addr_d;
         instr_valid <= instr_valid_d;
         instr       <= instr_d;
         instr_pc    <= instr_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      mem_req_d     = mem_req;
      mem_addr_d    = mem_addr;
      instr_valid_d = instr_valid;
      instr_d       = instr;
      instr_pc_d    = instr_pc;
      unique case (state_q)
         IDLE: begin
            if (run && !flush) begin
               mem_addr_d = pc_in;
               mem_req_d  = 1'b1;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               if (!flush) begin
                  instr_d       = mem_rdata;
                  instr_pc_d    = mem_addr;
                  instr_valid_d = 1'b1;
                  state_d       = HOLD;
               end else begin
                  state_d = IDLE;
               end
            end else if (tmo) begin
               mem_req_d = 1'b0;
               state_d   = ERR;
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end else if (tmo) begin
               mem_req_d = 1'b0;
               state_d   = ERR;
            end
         end
         HOLD: begin
            if (flush || instr_ready) begin
               instr_valid_d = 1'b0;
               state_d       = IDLE;
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign pc_advance = (state_q == HOLD) & instr_valid &
                       instr_ready & ~flush;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   logic             in_wait;

   assign in_wait = (state_q == REQ) || (state_q == DRAIN);
   assign tmo     = in_wait && !mem_ack &&
                    (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count restarts whenever a wait state is freshly entered (REQ or REQ->DRAIN)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         fetch_err <= 1'b0;
      end else begin
         if (tmo)
            fetch_err <= 1'b1;
         if (state_d != state_q &&
             (state_d == REQ || state_d == DRAIN))
            cnt <= '0;
         else if (in_wait && !mem_ack && !tmo)
            cnt <= cnt + 1'b1;
      end
   end
`else
   assign tmo       = 1'b0;
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed stimulus, queued
// expectations popped by a monitor on each accepted instruction.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        run, flush;
   logic [15:0] pc_in;
   logic        pc_advance;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        instr_valid, instr_ready;
   logic [15:0] instr, instr_pc;
   logic        fetch_err;

   int tests = 0;
   int fails = 0;
   int adv_cnt = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_W(16),
      .DATA_W(16),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .flush(flush),
      .pc_in(pc_in),
      .pc_advance(pc_advance),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr(instr),
      .instr_pc(instr_pc),
      .fetch_err(fetch_err)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted instruction must match the head of the queue
   always @(negedge clk) begin
      if (reset && instr_valid && instr_ready && !flush) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_accept", {instr_pc, instr}, 32'hFFFF_FFFF);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("sb_instr", {16'h0, instr}, {16'h0, e[31:16]});
            chk("sb_pc", {16'h0, instr_pc}, {16'h0, e[15:0]});
            chk("sb_adv", {31'h0, pc_advance}, 32'd1);
         end
      end
      if (reset && pc_advance) adv_cnt++;
   end

   initial begin
      reset = 1'b0; run = 1'b0; flush = 1'b0; pc_in = '0;
      mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'h0, mem_req}, 0);
      chk("rst_addr", {16'h0, mem_addr}, 0);
      chk("rst_valid", {31'h0, instr_valid}, 0);
      chk("rst_instr", {16'h0, instr}, 0);
      chk("rst_ipc", {16'h0, instr_pc}, 0);
      chk("rst_err", {31'h0, fetch_err}, 0);
      reset = 1'b1;

      // basic fetch with ack in first REQ cycle
      run = 1'b1; pc_in = 16'h0010; instr_ready = 1'b1;
      mem_rdata = 16'hA5C3;
      exp_q.push_back({16'hA5C3, 16'h0010});
      tick();
      chk("t1_req", {31'h0, mem_req}, 1);
      chk("t1_addr", {16'h0, mem_addr}, 32'h0010);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("t1_valid", {31'h0, instr_valid}, 1);
      chk("t1_req_drop", {31'h0, mem_req}, 0);
      chk("t1_adv", {31'h0, pc_advance}, 1);
      pc_in = 16'h0011;
      exp_q.push_back({16'h1234, 16'h0011});
      tick();
      chk("t1_idle_valid", {31'h0, instr_valid}, 0);
      chk("t1_idle_req", {31'h0, mem_req}, 0);
      tick();
      chk("t1_cadence", {31'h0, mem_req}, 1);

      // ack delayed 4 cycles, then decode stalls 3 cycles
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_req_hold", {31'h0, mem_req}, 1);
         chk("t2_addr_hold", {16'h0, mem_addr}, 32'h0011);
         chk("t2_no_valid", {31'h0, instr_valid}, 0);
         if (i < 4) tick();
      end
      mem_ack = 1'b1; mem_rdata = 16'h1234;
      tick();
      mem_ack = 1'b0;
      chk("t2_valid", {31'h0, instr_valid}, 1);
      for (int i = 0; i < 3; i++) begin
         chk("t3_instr", {16'h0, instr}, 32'h1234);
         chk("t3_ipc", {16'h0, instr_pc}, 32'h0011);
         chk("t3_no_adv", {31'h0, pc_advance}, 0);
         chk("t3_no_req", {31'h0, mem_req}, 0);
         if (i < 2) tick();
      end
      run = 1'b0; instr_ready = 1'b1;
      #1;
      chk("t3_adv", {31'h0, pc_advance}, 1);
      tick();
      chk("t3_release", {31'h0, instr_valid}, 0);

      // flush mid-REQ drains the stale read
      instr_ready = 1'b0; run = 1'b1; pc_in = 16'h0020;
      tick();
      chk("t4_addr", {16'h0, mem_addr}, 32'h0020);
      tick();
      flush = 1'b1; pc_in = 16'h0040;
      tick();
      flush = 1'b0;
      chk("t4_drain_req", {31'h0, mem_req}, 1);
      tick();
      chk("t4_drain_req2", {31'h0, mem_req}, 1);
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      tick();
      mem_ack = 1'b0;
      chk("t4_drain_done", {31'h0, mem_req}, 0);
      chk("t4_dead_dropped", {31'h0, instr_valid}, 0);
      mem_rdata = 16'hBEEF; instr_ready = 1'b1;
      exp_q.push_back({16'hBEEF, 16'h0040});
      tick();
      chk("t4_new_addr", {16'h0, mem_addr}, 32'h0040);
      chk("t4_new_req", {31'h0, mem_req}, 1);
      mem_ack = 1'b1; run = 1'b0;
      tick();
      mem_ack = 1'b0;
      chk("t4_valid", {31'h0, instr_valid}, 1);
      chk("t4_adv", {31'h0, pc_advance}, 1);
      tick();
      chk("t4_idle", {31'h0, instr_valid}, 0);

      // flush and ready in the same HOLD cycle
      run = 1'b1; pc_in = 16'h0050; mem_rdata = 16'h5555;
      tick();
      mem_ack = 1'b1; run = 1'b0;
      tick();
      mem_ack = 1'b0;
      chk("t5_valid", {31'h0, instr_valid}, 1);
      flush = 1'b1;
      #1;
      chk("t5_no_adv", {31'h0, pc_advance}, 0);
      tick();
      flush = 1'b0;
      chk("t5_dropped", {31'h0, instr_valid}, 0);
      chk("t5_idle", {31'h0, mem_req}, 0);

      // async reset mid-REQ, late ack ignored
      run = 1'b1; pc_in = 16'h0060;
      tick();
      chk("t6_req", {31'h0, mem_req}, 1);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_req", {31'h0, mem_req}, 0);
      chk("t6_async_addr", {16'h0, mem_addr}, 0);
      chk("t6_async_instr", {16'h0, instr}, 0);
      chk("t6_async_ipc", {16'h0, instr_pc}, 0);
      run = 1'b0; mem_ack = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      chk("t6_late_ack_valid", {31'h0, instr_valid}, 0);
      chk("t6_late_ack_req", {31'h0, mem_req}, 0);

`ifdef FETCH_TIMEOUT_EN
      run = 1'b1; pc_in = 16'h0070;
      tick();
      run = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("t7_wait_req", {31'h0, mem_req}, 1);
         chk("t7_wait_err", {31'h0, fetch_err}, 0);
         tick();
      end
      chk("t7_err", {31'h0, fetch_err}, 1);
      chk("t7_req_drop", {31'h0, mem_req}, 0);
      run = 1'b1;
      tick();
      chk("t7_sticky", {31'h0, fetch_err}, 1);
      chk("t7_stuck", {31'h0, mem_req}, 0);
      #2 reset = 1'b0;
      #1;
      chk("t7_rst_err", {31'h0, fetch_err}, 0);
      run = 1'b0;
      reset = 1'b1;
`else
      chk("t7_no_err", {31'h0, fetch_err}, 0);
`endif

      tick();
      chk("adv_count", adv_cnt, 3);
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
